// File: rtl/video_capture_fifo_if.sv
// Token read port of the video capture FIFO: head data, not-empty flag and consumer pop.
interface video_capture_fifo_if;
   logic [19:0] tok_data;
   logic        tok_valid;
   logic        tok_ready;

   modport master (output tok_data, output tok_valid, input tok_ready);
   modport slave  (input tok_data, input tok_valid, output tok_ready);
endinterface

// File: rtl/video_capture_fifo.sv
// Video capture stage: turns pixel/line/frame edges of the video output into a
// token stream (pixel, line-start, frame-end) buffered in a valid/ready FIFO.
//
// state        | meaning
// S_IDLE       | disarmed, waiting for arm
// S_WAIT_FRAME | armed, waiting for a frame-end edge to align on
// S_CAPTURE    | generating tokens until FRAMES frames have ended
// S_DONE       | flushing pending events, waiting for the FIFO to drain
module video_capture_fifo #(
   parameter int DEPTH_LOG2 = 6,
   parameter int FRAMES     = 1
) (
   input  logic                        clk_main,
   input  logic                        reset,
   input  logic                        pix_ce,
   input  logic                        nhbk,
   input  logic                        hvot,
   input  logic [17:0]                 rgb,
   input  logic                        arm,
   video_capture_fifo_if.master        tok,
   output logic                        busy,
   output logic                        overflow,
   output logic [7:0]                  frame_cnt
);

   localparam int                  DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [7:0]          FRAMES_W = 8'(FRAMES);

   localparam logic [1:0] T_PIX   = 2'b00;
   localparam logic [1:0] T_LINE  = 2'b01;
   localparam logic [1:0] T_FRAME = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_WAIT_FRAME, S_CAPTURE, S_DONE} state_t;
   state_t state, state_nxt;

   logic prev_pix_ce, prev_nhbk, prev_hvot;
   logic pe, le, fe;

   logic [8:0]  pix_cnt, pix_cnt_nxt, line_cnt, line_cnt_nxt;
   logic [7:0]  frame_cnt_nxt, frame_inc;
   logic        pend_line, pend_line_nxt, pend_pix, pend_pix_nxt;
   logic [17:0] pend_line_data, pend_line_data_nxt, pend_pix_data, pend_pix_data_nxt;
   logic [8:0]  lc, pc;
   logic [17:0] line_ev;
   logic        last_frame;
   logic        ovf_set_ev, ovf_clr;
   logic        wr_req;
   logic [19:0] wr_data;

   logic [19:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  fifo_valid, fifo_full, pop, wr_en, fifo_drop;

   assign pe = pix_ce & ~prev_pix_ce;
   assign le = nhbk & ~prev_nhbk;
   assign fe = ~hvot & prev_hvot;

   assign frame_inc = frame_cnt + 8'd1;

   always_comb begin
      state_nxt          = state;
      pix_cnt_nxt        = pix_cnt;
      line_cnt_nxt       = line_cnt;
      frame_cnt_nxt      = frame_cnt;
      pend_line_nxt      = pend_line;
      pend_line_data_nxt = pend_line_data;
      pend_pix_nxt       = pend_pix;
      pend_pix_data_nxt  = pend_pix_data;
      ovf_set_ev         = 1'b0;
      ovf_clr            = 1'b0;
      wr_req             = 1'b0;
      wr_data            = '0;
      lc                 = line_cnt;
      pc                 = pix_cnt;
      line_ev            = '0;
      last_frame         = 1'b0;

      case (state)
         S_IDLE: begin
            if (arm) begin
               state_nxt     = S_WAIT_FRAME;
               ovf_clr       = 1'b1;
               frame_cnt_nxt = '0;
               pend_line_nxt = 1'b0;
               pend_pix_nxt  = 1'b0;
            end
         end

         S_WAIT_FRAME: begin
            if (fe) begin
               state_nxt    = S_CAPTURE;
               line_cnt_nxt = '0;
               pix_cnt_nxt  = '0;
            end
         end

         S_CAPTURE: begin
            // Events are applied to the counters in priority order (frame, line,
            // pixel) so payloads match event order even when one gets deferred.
            if (fe) begin
               frame_cnt_nxt = frame_inc;
               lc            = '0;
               wr_req        = 1'b1;
               wr_data       = {T_FRAME, 10'd0, frame_inc};
               last_frame    = (frame_inc == FRAMES_W);
               if (last_frame) state_nxt = S_DONE;
            end else if (pend_line) begin
               wr_req        = 1'b1;
               wr_data       = {T_LINE, pend_line_data};
               pend_line_nxt = 1'b0;
            end

            if (le) begin
               line_ev = {lc, pc};
               lc      = lc + 9'd1;
               pc      = '0;
               if (!wr_req) begin
                  wr_req  = 1'b1;
                  wr_data = {T_LINE, line_ev};
               end else if (!pend_line_nxt) begin
                  pend_line_nxt      = 1'b1;
                  pend_line_data_nxt = line_ev;
               end else begin
                  ovf_set_ev = 1'b1;
               end
            end

            if (!wr_req && pend_pix) begin
               wr_req       = 1'b1;
               wr_data      = {T_PIX, pend_pix_data};
               pend_pix_nxt = 1'b0;
            end

            // A pixel coinciding with the final frame end belongs to no frame.
            if (pe && !last_frame) begin
               if (pc != 9'd511) pc = pc + 9'd1;
               if (!wr_req) begin
                  wr_req  = 1'b1;
                  wr_data = {T_PIX, rgb};
               end else if (!pend_pix_nxt) begin
                  pend_pix_nxt      = 1'b1;
                  pend_pix_data_nxt = rgb;
               end else begin
                  ovf_set_ev = 1'b1;
               end
            end

            line_cnt_nxt = lc;
            pix_cnt_nxt  = pc;
         end

         S_DONE: begin
            if (pend_line) begin
               wr_req        = 1'b1;
               wr_data       = {T_LINE, pend_line_data};
               pend_line_nxt = 1'b0;
            end else if (pend_pix) begin
               wr_req       = 1'b1;
               wr_data      = {T_PIX, pend_pix_data};
               pend_pix_nxt = 1'b0;
            end else if (count == '0) begin
               state_nxt = S_IDLE;
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   assign fifo_valid = (count != '0);
   assign fifo_full  = (count == FULL_CNT);
   assign pop        = fifo_valid & tok.tok_ready;
   assign wr_en      = wr_req & (~fifo_full | pop);
   assign fifo_drop  = wr_req & fifo_full & ~pop;

   assign tok.tok_valid = fifo_valid;
   assign tok.tok_data  = fifo_valid ? mem[rd_ptr] : '0;

   assign busy = (state == S_WAIT_FRAME) || (state == S_CAPTURE);

   always_ff @(posedge clk_main) begin
      if (reset) begin
         state          <= S_IDLE;
         prev_pix_ce    <= 1'b0;
         prev_nhbk      <= 1'b0;
         prev_hvot      <= 1'b0;
         pix_cnt        <= '0;
         line_cnt       <= '0;
         frame_cnt      <= '0;
         pend_line      <= 1'b0;
         pend_line_data <= '0;
         pend_pix       <= 1'b0;
         pend_pix_data  <= '0;
         overflow       <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
      end else begin
         state          <= state_nxt;
         prev_pix_ce    <= pix_ce;
         prev_nhbk      <= nhbk;
         prev_hvot      <= hvot;
         pix_cnt        <= pix_cnt_nxt;
         line_cnt       <= line_cnt_nxt;
         frame_cnt      <= frame_cnt_nxt;
         pend_line      <= pend_line_nxt;
         pend_line_data <= pend_line_data_nxt;
         pend_pix       <= pend_pix_nxt;
         pend_pix_data  <= pend_pix_data_nxt;

         if (ovf_clr)                     overflow <= 1'b0;
         else if (ovf_set_ev | fifo_drop) overflow <= 1'b1;

         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the head is masked by tok_valid.
   always_ff @(posedge clk_main) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: tb/tb_video_capture_fifo.sv
// Directed bench for video_capture_fifo: three instances cover the default
// configuration, a 4-deep FIFO and a two-frame capture.
module tb_video_capture_fifo;

   typedef logic [19:0] tok_q_t[$];

   logic        clk_main = 1'b0;
   logic        reset    = 1'b1;
   logic        pix_ce   = 1'b0;
   logic        nhbk     = 1'b0;
   logic        hvot     = 1'b1;
   logic [17:0] rgb      = '0;
   logic        arm_a = 1'b0, arm_b = 1'b0, arm_c = 1'b0;
   logic        busy_a, busy_b, busy_c;
   logic        ovf_a, ovf_b, ovf_c;
   logic [7:0]  fcnt_a, fcnt_b, fcnt_c;

   int total = 0;
   int bad   = 0;

   tok_q_t q_a, q_b, q_c, exp_q;

   video_capture_fifo_if tok_a ();
   video_capture_fifo_if tok_b ();
   video_capture_fifo_if tok_c ();

   video_capture_fifo #(.DEPTH_LOG2(6), .FRAMES(1)) dut_a (
      .clk_main(clk_main), .reset(reset), .pix_ce(pix_ce), .nhbk(nhbk), .hvot(hvot),
      .rgb(rgb), .arm(arm_a), .tok(tok_a.master), .busy(busy_a), .overflow(ovf_a),
      .frame_cnt(fcnt_a));

   video_capture_fifo #(.DEPTH_LOG2(2), .FRAMES(1)) dut_b (
      .clk_main(clk_main), .reset(reset), .pix_ce(pix_ce), .nhbk(nhbk), .hvot(hvot),
      .rgb(rgb), .arm(arm_b), .tok(tok_b.master), .busy(busy_b), .overflow(ovf_b),
      .frame_cnt(fcnt_b));

   video_capture_fifo #(.DEPTH_LOG2(6), .FRAMES(2)) dut_c (
      .clk_main(clk_main), .reset(reset), .pix_ce(pix_ce), .nhbk(nhbk), .hvot(hvot),
      .rgb(rgb), .arm(arm_c), .tok(tok_c.master), .busy(busy_c), .overflow(ovf_c),
      .frame_cnt(fcnt_c));

   always #5 clk_main = ~clk_main;

   // Record every popped token in order.
   always @(posedge clk_main) begin
      if (tok_a.tok_valid && tok_a.tok_ready) q_a.push_back(tok_a.tok_data);
      if (tok_b.tok_valid && tok_b.tok_ready) q_b.push_back(tok_b.tok_data);
      if (tok_c.tok_valid && tok_c.tok_ready) q_c.push_back(tok_c.tok_data);
   end

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_tokens(input string tag, input tok_q_t got, input tok_q_t exp);
      chk_val({tag, "_count"}, got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         chk_val($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : 20'hFFFFF, exp[i]);
   endtask

   task automatic tick();
      @(posedge clk_main);
      #1;
   endtask

   task automatic pix(input logic [17:0] v);
      rgb = v; pix_ce = 1'b1; tick(); pix_ce = 1'b0; tick();
   endtask

   task automatic line_p();
      nhbk = 1'b1; tick(); nhbk = 1'b0; tick();
   endtask

   task automatic frame_p();
      hvot = 1'b0; tick(); hvot = 1'b1; tick();
   endtask

   task automatic do_reset();
      reset = 1'b1; repeat (2) tick(); reset = 1'b0; tick();
      q_a.delete(); q_b.delete(); q_c.delete();
   endtask

   initial begin
      tok_a.tok_ready = 1'b0;
      tok_b.tok_ready = 1'b0;
      tok_c.tok_ready = 1'b0;

      // Reset state and alignment to the first frame end
      do_reset();
      chk_val("rst_valid", tok_a.tok_valid, 1'b0);
      chk_val("rst_data", tok_a.tok_data, 20'h0);
      chk_val("rst_busy", busy_a, 1'b0);
      chk_val("rst_ovf", ovf_a, 1'b0);
      chk_val("rst_fcnt", fcnt_a, 8'd0);
      tok_a.tok_ready = 1'b1;
      arm_a = 1'b1; tick(); arm_a = 1'b0;
      chk_val("arm_busy", busy_a, 1'b1);
      pix(18'h00001); line_p(); pix(18'h00002);
      chk_val("wait_no_tok", q_a.size() + 32'(tok_a.tok_valid), 0);

      // One frame, two lines
      frame_p(); line_p();
      pix(18'h3F000); pix(18'h00FC0); pix(18'h0003F);
      line_p(); frame_p();
      repeat (10) tick();
      exp_q = '{20'h40000, 20'h3F000, 20'h00FC0, 20'h0003F, 20'h40203, 20'h80001};
      chk_tokens("frame1", q_a, exp_q);
      chk_val("f1_busy", busy_a, 1'b0);
      chk_val("f1_fcnt", fcnt_a, 8'd1);
      chk_val("f1_valid", tok_a.tok_valid, 1'b0);

      // Coincident line and pixel edges
      do_reset();
      arm_a = 1'b1; tick(); arm_a = 1'b0;
      frame_p();
      rgb = 18'h12345; nhbk = 1'b1; pix_ce = 1'b1; tick();
      nhbk = 1'b0; pix_ce = 1'b0; tick();
      line_p(); frame_p();
      repeat (10) tick();
      exp_q = '{20'h40000, 20'h12345, 20'h40201, 20'h80001};
      chk_tokens("coinc", q_a, exp_q);
      chk_val("coinc_ovf", ovf_a, 1'b0);

      // Overflow on a 4-deep FIFO
      do_reset();
      tok_a.tok_ready = 1'b0;
      arm_b = 1'b1; tick(); arm_b = 1'b0;
      frame_p();
      for (int i = 1; i <= 6; i++) pix(18'(i));
      chk_val("ovf_valid", tok_b.tok_valid, 1'b1);
      chk_val("ovf_set", ovf_b, 1'b1);
      tok_b.tok_ready = 1'b1;
      repeat (8) tick();
      exp_q = '{20'h00001, 20'h00002, 20'h00003, 20'h00004};
      chk_tokens("ovf_drain", q_b, exp_q);
      chk_val("ovf_sticky", ovf_b, 1'b1);

      // Two frames of two lines
      do_reset();
      tok_c.tok_ready = 1'b1;
      arm_c = 1'b1; tick(); arm_c = 1'b0;
      frame_p();
      line_p(); pix(18'h00011); line_p(); pix(18'h00022); frame_p();
      chk_val("f2_mid_busy", busy_c, 1'b1);
      line_p(); pix(18'h00033); line_p(); pix(18'h00044); frame_p();
      repeat (10) tick();
      exp_q = '{20'h40000, 20'h00011, 20'h40201, 20'h00022, 20'h80001,
                20'h40001, 20'h00033, 20'h40201, 20'h00044, 20'h80002};
      chk_tokens("frames2", q_c, exp_q);
      chk_val("f2_fcnt", fcnt_c, 8'd2);
      chk_val("f2_busy", busy_c, 1'b0);
      arm_c = 1'b1; tick(); arm_c = 1'b0;
      chk_val("f2_rearm", busy_c, 1'b1);

      // Reset in the middle of a capture
      do_reset();
      tok_a.tok_ready = 1'b0;
      arm_a = 1'b1; tick(); arm_a = 1'b0;
      frame_p();
      pix(18'h00101); pix(18'h00202); pix(18'h00303);
      chk_val("mid_valid_pre", tok_a.tok_valid, 1'b1);
      reset = 1'b1; tick();
      chk_val("mid_valid", tok_a.tok_valid, 1'b0);
      chk_val("mid_busy", busy_a, 1'b0);
      chk_val("mid_fcnt", fcnt_a, 8'd0);
      reset = 1'b0; tick();
      q_a.delete();
      tok_a.tok_ready = 1'b1;
      arm_a = 1'b1; tick(); arm_a = 1'b0;
      frame_p(); line_p(); pix(18'h0002A); frame_p();
      repeat (10) tick();
      exp_q = '{20'h40000, 20'h0002A, 20'h80001};
      chk_tokens("post_rst", q_a, exp_q);
      chk_val("post_fcnt", fcnt_a, 8'd1);
      chk_val("post_busy", busy_a, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
